// File: rtl/smult_pkg.sv
// Shared state encoding and sizing helper for the shift-add multiplier.
package smult_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Ceiling log2 with a floor of 1 so a counter never collapses to zero width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_add_mult_n_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/shift_add_mult_n.sv
// Sequential shift-add multiplier: WIDTH iterations per product, optional
// signed mode via sign-magnitude conversion, result held until Ack.
module shift_add_mult_n
  import smult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               St,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic               Ack,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] Result
);

  localparam int CW = clog2(WIDTH);

  logic [1:0]         state, state_nxt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand_mag;
  logic [CW-1:0]      count;
  logic               neg_flag;

  logic               mode;
  logic [WIDTH-1:0]   mplier_abs, mcand_abs;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] prod_signed;
  logic               last_iter;

  // With SIGNED_EN=0 mode is constant 0 and the negators reduce to wires.
  assign mode      = Signed & SIGNED_EN;
  assign last_iter = (count == CW'(WIDTH - 1));

  cond_negate #(.N(WIDTH)) u_mplier_abs (
    .x(Mplier), .neg(mode & Mplier[WIDTH-1]), .y(mplier_abs)
  );

  cond_negate #(.N(WIDTH)) u_mcand_abs (
    .x(Mcand), .neg(mode & Mcand[WIDTH-1]), .y(mcand_abs)
  );

  cond_negate #(.N(2*WIDTH)) u_result (
    .x(acc[2*WIDTH-1:0]), .neg(neg_flag), .y(prod_signed)
  );

  // Upper half plus optional addend; acc[2W] is always 0 here, so the carry
  // lands in bit W of upper before the shift.
  assign upper = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, mcand_mag})
                        : acc[2*WIDTH:WIDTH];

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = St ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last_iter ? S_DONE : S_RUN;
      S_DONE:  state_nxt = Ack ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: Result is forced to zero outside DONE so no partial value leaks.
  always_comb begin
    Busy   = (state == S_RUN);
    Done   = (state == S_DONE);
    Result = (state == S_DONE) ? prod_signed : '0;
  end

  // Datapath: capture magnitudes on start, then add-and-shift once per edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc       <= '0;
      mcand_mag <= '0;
      count     <= '0;
      neg_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (St) begin
          acc       <= {{(WIDTH+1){1'b0}}, mplier_abs};
          mcand_mag <= mcand_abs;
          count     <= '0;
          neg_flag  <= mode & (Mplier[WIDTH-1] ^ Mcand[WIDTH-1]);
        end
        S_RUN: begin
          acc   <= {upper, acc[WIDTH-1:0]} >> 1;
          count <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_n.sv
// Scoreboard bench: driver pushes reference products, monitor pops on Done.
module tb_shift_add_mult_n;

  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Rst_n = 1'b0;
  logic           St = 1'b0, Signed = 1'b0, Ack = 1'b0;
  logic [W-1:0]   Mplier = '0, Mcand = '0;
  logic           Busy, Done;
  logic [2*W-1:0] Result;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic           prev_done = 1'b0;
  logic [2*W-1:0] held = '0;

  shift_add_mult_n #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .St(St), .Signed(Signed),
    .Mplier(Mplier), .Mcand(Mcand), .Ack(Ack),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer multiply, truncated to the result width.
  function automatic logic [2*W-1:0] ref_prod(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'({1'b0, a}) * longint'({1'b0, b});
    return p[2*W-1:0];
  endfunction

  // Monitor: compare on Done rising, check hold while Done, zero otherwise.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      prev_done = 1'b0;
    end else begin
      check("busy_done_exclusive", 64'(Busy & Done), 64'd0);
      if (Done && !prev_done) begin
        if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("result", 64'(Result), 64'(exp_q.pop_front()));
        held = Result;
      end else if (Done) begin
        check("result_hold", 64'(Result), 64'(held));
      end else begin
        check("result_zero_idle", 64'(Result), 64'd0);
      end
      prev_done = Done;
    end
  end

  task automatic run_op(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ack_dly, input bit st_run, input bit st_done, input bit st_ack);
    int n;
    @(negedge Clk);
    Signed = sm; Mplier = a; Mcand = b; St = 1'b1;
    exp_q.push_back(ref_prod(sm, a, b));
    @(negedge Clk);
    St = 1'b0;
    Mplier = W'($urandom); Mcand = W'($urandom); Signed = 1'($urandom);
    n = 0;
    while (!Done && n < 4 * W) begin
      St  = st_run && (n == 2);
      Ack = st_run && (n == 3);
      @(negedge Clk);
      n++;
    end
    St = 1'b0; Ack = 1'b0;
    check("latency", 64'(n), 64'(W));
    for (int i = 0; i < ack_dly; i++) begin
      St = st_done;
      @(negedge Clk);
      check("done_held", 64'(Done), 64'd1);
    end
    Ack = 1'b1; St = st_ack;
    @(negedge Clk);
    Ack = 1'b0; St = 1'b0;
    check("ack_done_low", 64'(Done), 64'd0);
    check("ack_no_restart", 64'(Busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_result", 64'(Result), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    run_op(1'b0, 8'd13, 8'd11, 2, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 8'h80, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 8'h7F, 1, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'hFD, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 5, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-run: outputs must clear before the next edge.
    @(negedge Clk);
    Signed = 1'b0; Mplier = 8'd13; Mcand = 8'd11; St = 1'b1;
    exp_q.push_back(ref_prod(1'b0, 8'd13, 8'd11));
    @(negedge Clk);
    St = 1'b0;
    repeat (3) @(negedge Clk);
    check("mid_run_busy", 64'(Busy), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("async_busy", 64'(Busy), 64'd0);
    check("async_done", 64'(Done), 64'd0);
    check("async_result", 64'(Result), 64'd0);
    void'(exp_q.pop_front());
    @(negedge Clk);
    Rst_n = 1'b1;
    run_op(1'b0, 8'd7, 8'd9, 1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 60; k++)
      run_op(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom));

    repeat (2) @(negedge Clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
